// File: rtl/multicycle_cu_seq.sv
// Multi-cycle control unit: binary-coded step/type registers decoded to one-hot,
// variable-length step sequencing with memory-ready stalls, HALT parking and a saturating retire counter.
module multicycle_cu_seq #(
    parameter int OPW      = 6,
    parameter int SKIP_EN  = 1,
    parameter int MEM_WAIT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OPW-1:0]   opcode,
    input  logic             beq_eq,
    input  logic             mem_ready,
    output logic             inst_read,
    output logic             ld_ir,
    output logic             reg_read,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             inc_pc,
    output logic             ld_pc,
    output logic [7:0]       step,
    output logic [7:0]       itype,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S0 = 3'd0, S1 = 3'd1, S2 = 3'd2, S3 = 3'd3,
        S4 = 3'd4, S5 = 3'd5, S6 = 3'd6, S7 = 3'd7
    } step_e;

    step_e            step_q, step_d;
    logic [2:0]       type_q, type_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             mem_ok;
    logic             is_mem;
    logic             retire;
    logic             unused_opcode;

    // Only opcode[2:0] selects the type; the upper bits are intentionally ignored.
    assign unused_opcode = ^opcode;

    always_ff @(posedge clk) begin
        if (rst) begin
            step_q    <= S7;
            type_q    <= '0;
            halted_q  <= 1'b0;
            retired_q <= '0;
        end else begin
            step_q    <= step_d;
            type_q    <= type_d;
            halted_q  <= halted_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        mem_ok    = (MEM_WAIT == 0) ? 1'b1 : mem_ready;
        is_mem    = (type_q == 3'd4) || (type_q == 3'd5);
        step_d    = step_q;
        type_d    = type_q;
        halted_d  = halted_q;
        retire    = 1'b0;
        case (step_q)
            S0: if (mem_ok) step_d = S1;
            S1: step_d = S2;
            S2: begin
                type_d = opcode[2:0];
                if (opcode[2:0] == 3'd7) begin
                    step_d   = S7;
                    halted_d = 1'b1;
                end else begin
                    step_d = S3;
                end
            end
            S3: step_d = ((SKIP_EN == 0) || is_mem) ? S4 : S5;
            // Non-memory types only reach S4 with skipping disabled and never stall there.
            S4: if (!is_mem || mem_ok) step_d = S5;
            S5: begin
                if ((SKIP_EN == 0) || (type_q == 3'd6)) begin
                    step_d = S6;
                end else begin
                    step_d = S0;
                    retire = 1'b1;
                end
            end
            S6: begin
                step_d = S0;
                retire = 1'b1;
            end
            S7: if (!halted_q) step_d = S0;
            default: step_d = S7;
        endcase
        retired_d = (retire && (retired_q != '1)) ? retired_q + CNT_W'(1) : retired_q;
    end

    always_comb begin
        step      = 8'b1 << step_q;
        itype     = 8'b1 << type_q;
        inst_read = (step_q == S0);
        ld_ir     = (step_q == S1);
        reg_read  = (step_q == S2);
        mem_read  = (step_q == S4) && (type_q == 3'd4);
        mem_write = (step_q == S4) && (type_q == 3'd5);
        reg_write = (step_q == S5) && (type_q <= 3'd4);
        inc_pc    = (step_q == S5) && (type_q != 3'd7);
        ld_pc     = (step_q == S6) && (type_q == 3'd6) && beq_eq;
        halted    = halted_q;
        retired   = retired_q;
    end

endmodule

// File: tb/tb_multicycle_cu_seq.sv
// Randomized bench: per-instruction step paths from the instruction-type rules,
// memory steps repeated while mem_ready is low; plus SKIP_EN=0 and CNT_W=3 instances.
module tb_multicycle_cu_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, rst_ns, rst_c3;
    logic [5:0] opcode;
    logic       beq_eq, mem_ready;

    logic        inst_read, ld_ir, reg_read, mem_read, mem_write, reg_write, inc_pc, ld_pc, halted;
    logic [7:0]  step, itype;
    logic [15:0] retired;

    logic        inst_read_ns, ld_ir_ns, reg_read_ns, mem_read_ns, mem_write_ns, reg_write_ns;
    logic        inc_pc_ns, ld_pc_ns, halted_ns;
    logic [7:0]  step_ns, itype_ns;
    logic [15:0] retired_ns;

    logic        inst_read_c3, ld_ir_c3, reg_read_c3, mem_read_c3, mem_write_c3, reg_write_c3;
    logic        inc_pc_c3, ld_pc_c3, halted_c3;
    logic [7:0]  step_c3, itype_c3;
    logic [2:0]  retired_c3;

    multicycle_cu_seq dut (
        .clk(clk), .rst(rst), .opcode(opcode), .beq_eq(beq_eq), .mem_ready(mem_ready),
        .inst_read(inst_read), .ld_ir(ld_ir), .reg_read(reg_read), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .inc_pc(inc_pc), .ld_pc(ld_pc),
        .step(step), .itype(itype), .halted(halted), .retired(retired)
    );

    multicycle_cu_seq #(.SKIP_EN(0)) dut_ns (
        .clk(clk), .rst(rst_ns), .opcode(opcode), .beq_eq(beq_eq), .mem_ready(mem_ready),
        .inst_read(inst_read_ns), .ld_ir(ld_ir_ns), .reg_read(reg_read_ns), .mem_read(mem_read_ns),
        .mem_write(mem_write_ns), .reg_write(reg_write_ns), .inc_pc(inc_pc_ns), .ld_pc(ld_pc_ns),
        .step(step_ns), .itype(itype_ns), .halted(halted_ns), .retired(retired_ns)
    );

    multicycle_cu_seq #(.CNT_W(3)) dut_c3 (
        .clk(clk), .rst(rst_c3), .opcode(opcode), .beq_eq(beq_eq), .mem_ready(mem_ready),
        .inst_read(inst_read_c3), .ld_ir(ld_ir_c3), .reg_read(reg_read_c3), .mem_read(mem_read_c3),
        .mem_write(mem_write_c3), .reg_write(reg_write_c3), .inc_pc(inc_pc_c3), .ld_pc(ld_pc_c3),
        .step(step_c3), .itype(itype_c3), .halted(halted_c3), .retired(retired_c3)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model state: step path of the current instruction and architectural counters.
    int path[$];
    int pi;
    int cur_t;
    int exp_type;
    int exp_ret;
    bit exp_halted;
    bit fresh;
    bit instr_done;

    function automatic logic [7:0] onehot(input int s);
        return 8'(1) << s;
    endfunction

    function automatic logic [8:0] exp_ctrl(input int s, input int t, input logic beq, input bit hlt);
        return {hlt, (s == 6 && t == 6 && beq), (s == 5 && t != 7), (s == 5 && t <= 4),
                (s == 4 && t == 5), (s == 4 && t == 4), (s == 2), (s == 1), (s == 0)};
    endfunction

    function automatic logic [8:0] ctrl_main();
        return {halted, ld_pc, inc_pc, reg_write, mem_write, mem_read, reg_read, ld_ir, inst_read};
    endfunction

    function automatic logic [8:0] ctrl_ns();
        return {halted_ns, ld_pc_ns, inc_pc_ns, reg_write_ns, mem_write_ns, mem_read_ns,
                reg_read_ns, ld_ir_ns, inst_read_ns};
    endfunction

    task automatic start_instr(input int t);
        logic [2:0] hi;
        hi     = 3'($urandom);
        opcode = {hi, 3'(t)};
        cur_t  = t;
        path.delete();
        if (fresh) path.push_back(7);
        fresh = 1'b0;
        path.push_back(0);
        path.push_back(1);
        path.push_back(2);
        if (t == 7) begin
            path.push_back(7);
        end else begin
            path.push_back(3);
            if (t == 4 || t == 5) path.push_back(4);
            path.push_back(5);
            if (t == 6) path.push_back(6);
        end
        pi         = 0;
        instr_done = 1'b0;
    endtask

    task automatic cycle(input logic mr, input logic beq);
        int s;
        mem_ready = mr;
        beq_eq    = beq;
        @(negedge clk);
        s = path[pi];
        chk("step", 32'(step), 32'(onehot(s)));
        chk("itype", 32'(itype), 32'(onehot(exp_type)));
        chk("ctrl", 32'(ctrl_main()), 32'(exp_ctrl(s, exp_type, beq, exp_halted)));
        chk("retired", 32'(retired), 32'(exp_ret));
        @(posedge clk);
        #1;
        if (s == 2) exp_type = cur_t;
        if (!((s == 0 || s == 4) && !mr) && !exp_halted) begin
            if (pi < path.size() - 1) begin
                pi++;
                if (path[pi] == 7) exp_halted = 1'b1;
            end else begin
                instr_done = 1'b1;
                if (exp_ret < 65535) exp_ret++;
            end
        end
    endtask

    // mode 0: random mem_ready; 1: always ready; 2: three stall cycles in S4. beq 2 = random.
    task automatic run_instr(input int t, input int mode, input int beq);
        int   stalls;
        logic mr, b;
        stalls = 3;
        start_instr(t);
        for (int n = 0; n < 200 && !instr_done && !exp_halted; n++) begin
            if (mode == 0) mr = ($urandom_range(0, 3) != 0);
            else if (mode == 2 && path[pi] == 4 && stalls > 0) begin
                mr = 1'b0;
                stalls--;
            end else mr = 1'b1;
            b = (beq == 2) ? 1'($urandom_range(0, 1)) : 1'(beq);
            cycle(mr, b);
        end
        chk("instr_end", 32'(instr_done || exp_halted), 32'd1);
    endtask

    task automatic do_reset(input int n);
        rst       = 1'b1;
        mem_ready = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
            chk("rst_step", 32'(step), 32'h80);
            chk("rst_itype", 32'(itype), 32'h01);
            chk("rst_ctrl", 32'(ctrl_main()), 32'd0);
            chk("rst_retired", 32'(retired), 32'd0);
        end
        rst        = 1'b0;
        exp_type   = 0;
        exp_ret    = 0;
        exp_halted = 1'b0;
        fresh      = 1'b1;
    endtask

    initial begin
        rst = 1'b1; rst_ns = 1'b1; rst_c3 = 1'b1;
        opcode = '0; beq_eq = 1'b0; mem_ready = 1'b1;
        do_reset(2);

        run_instr(0, 1, 0);
        run_instr(4, 2, 0);
        run_instr(6, 1, 1);
        run_instr(6, 1, 0);
        repeat (40) run_instr($urandom_range(0, 6), 0, 2);

        run_instr(7, 0, 2);
        repeat (10) cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        do_reset(2);
        run_instr(0, 0, 2);

        // Abort a store while it is stalled in S4.
        start_instr(5);
        for (int n = 0; n < 20 && path[pi] != 4; n++) cycle(1'b1, 1'b0);
        chk("sw_in_s4", 32'(path[pi]), 32'd4);
        cycle(1'b0, 1'b0);
        do_reset(1);
        repeat (5) run_instr($urandom_range(0, 6), 0, 2);

        // Hold the main unit in reset; release the SKIP_EN=0 and CNT_W=3 units on ALU instructions.
        rst       = 1'b1;
        opcode    = '0;
        mem_ready = 1'b1;
        beq_eq    = 1'b0;
        @(posedge clk);
        #1;
        rst_ns = 1'b0;
        rst_c3 = 1'b0;
        for (int c = 0; c < 60; c++) begin
            int s_ns, s_c3, r_ns, r_c3;
            int c3_path[5];
            c3_path = '{0, 1, 2, 3, 5};
            s_ns = (c == 0) ? 7 : (c - 1) % 7;
            r_ns = (c == 0) ? 0 : (c - 1) / 7;
            s_c3 = (c == 0) ? 7 : c3_path[(c - 1) % 5];
            r_c3 = (c == 0) ? 0 : (c - 1) / 5;
            if (r_c3 > 7) r_c3 = 7;
            @(negedge clk);
            chk("ns_step", 32'(step_ns), 32'(onehot(s_ns)));
            chk("ns_ctrl", 32'(ctrl_ns()), 32'(exp_ctrl(s_ns, 0, 1'b0, 1'b0)));
            chk("ns_retired", 32'(retired_ns), 32'(r_ns));
            chk("c3_step", 32'(step_c3), 32'(onehot(s_c3)));
            chk("c3_retired", 32'(retired_c3), 32'(r_c3));
            @(posedge clk);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
